sccb_init_sequencer: RTL and testbench

SCCB_INIT_SEQUENCER -- requirements
Module: sccb_init_sequencer

---
 rtl/sccb_init_sequencer_pkg.sv | 29 ++
 rtl/sccb_init_rom.sv | 21 ++
 rtl/sccb_init_sequencer.sv | 172 +++++++++++++++++
 tb/tb_sccb_init_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sccb_init_sequencer_pkg.sv
// Shared types and constants for the SCCB camera register init sequencer.
package sccb_init_sequencer_pkg;

  localparam int unsigned ENTRY_W = 16;
  localparam int unsigned IDX_W   = 8;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned CNT_W   = 32;

  localparam logic [BYTE_W-1:0] END_MARK   = 8'hFF;
  localparam logic [BYTE_W-1:0] DELAY_MARK = 8'hFE;
  localparam logic [IDX_W-1:0]  LAST_IDX   = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PWRUP,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_DELAY,
    S_DONE,
    S_ERROR
  } state_e;

  typedef struct packed {
    logic [BYTE_W-1:0] addr;
    logic [BYTE_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/sccb_init_rom.sv
// Camera bring-up register table: {sub-address, data} per index, read combinationally.
module sccb_init_rom
  import sccb_init_sequencer_pkg::*;
(
  input  logic [IDX_W-1:0]   index,
  output logic [ENTRY_W-1:0] entry
);

  // Soft reset, clock prescaler, settle delay, scaling; unused slots read as end marker.
  always_comb begin
    entry = {END_MARK, 8'h00};
    case (index)
      8'd0:    entry = {8'h12, 8'h80};
      8'd1:    entry = {8'h11, 8'h01};
      8'd2:    entry = {DELAY_MARK, 8'h02};
      8'd3:    entry = {8'h6B, 8'h0A};
      default: entry = {END_MARK, 8'h00};
    endcase
  end

endmodule

// File: rtl/sccb_init_sequencer.sv
// Walks the init ROM after power-up, issuing SCCB writes with NACK retry and table delays.
module sccb_init_sequencer
  import sccb_init_sequencer_pkg::*;
#(
  parameter logic [7:0]  DEV_ID       = 8'h42,
  parameter int unsigned PWRUP_CYCLES = 1000,
  parameter int unsigned DELAY_UNIT   = 50000,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic              PCLK,
  input  logic              PRESETN,
  input  logic              start,
  output logic              sccb_req,
  output logic [BYTE_W-1:0] sccb_id,
  output logic [BYTE_W-1:0] sccb_addr,
  output logic [BYTE_W-1:0] sccb_data,
  input  logic              sccb_done,
  input  logic              sccb_nack,
  output logic              busy,
  output logic              cfg_done,
  output logic              cfg_err,
  output logic [IDX_W-1:0]  err_index
);

  localparam logic [BYTE_W-1:0] RETRY_LIMIT = BYTE_W'(MAX_RETRY);
  localparam logic [CNT_W-1:0]  PWRUP_LOAD  = CNT_W'(PWRUP_CYCLES - 1);

  state_e             state_q, state_d;
  logic               start_q;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [BYTE_W-1:0]  retry_q, retry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               req_q, req_d;
  logic [BYTE_W-1:0]  addr_q, addr_d;
  logic [BYTE_W-1:0]  data_q, data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [IDX_W-1:0]   err_idx_q, err_idx_d;

  logic [ENTRY_W-1:0] rom_entry;
  entry_t             entry;
  logic               start_rise;

  sccb_init_rom u_rom (
    .index (idx_q),
    .entry (rom_entry)
  );

  assign entry      = entry_t'(rom_entry);
  assign start_rise = start & ~start_q;

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q   <= S_IDLE;
      start_q   <= 1'b1;
      idx_q     <= '0;
      retry_q   <= '0;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      start_q   <= start;
      idx_q     <= idx_d;
      retry_q   <= retry_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
    end
  end

  // One down-counter serves both the power-up wait and table delays.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    retry_d   = retry_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    addr_d    = addr_q;
    data_d    = data_q;
    err_idx_d = err_idx_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start_rise) begin
          state_d   = S_PWRUP;
          idx_d     = '0;
          retry_d   = '0;
          cnt_d     = PWRUP_LOAD;
          err_idx_d = '0;
        end
      end
      S_PWRUP: begin
        if (cnt_q == '0) begin
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_FETCH: begin
        if (entry.addr == END_MARK || idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else if (entry.addr == DELAY_MARK) begin
          if (entry.data == '0) begin
            idx_d = idx_q + IDX_W'(1);
          end else begin
            cnt_d   = CNT_W'(entry.data) * CNT_W'(DELAY_UNIT) - CNT_W'(1);
            state_d = S_DELAY;
          end
        end else begin
          addr_d  = entry.addr;
          data_d  = entry.data;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        req_d   = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (sccb_done) begin
          req_d = 1'b0;
          if (!sccb_nack) begin
            idx_d   = idx_q + IDX_W'(1);
            retry_d = '0;
            state_d = S_FETCH;
          end else if (retry_q < RETRY_LIMIT) begin
            retry_d = retry_q + BYTE_W'(1);
            state_d = S_ISSUE;
          end else begin
            err_idx_d = idx_q;
            state_d   = S_ERROR;
          end
        end
      end
      S_DELAY: begin
        if (cnt_q == '0) begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = !(state_d == S_IDLE || state_d == S_DONE || state_d == S_ERROR);
    done_d = (state_d == S_DONE);
    err_d  = (state_d == S_ERROR);
  end

  assign sccb_id   = DEV_ID;
  assign sccb_req  = req_q;
  assign sccb_addr = addr_q;
  assign sccb_data = data_q;
  assign busy      = busy_q;
  assign cfg_done  = done_q;
  assign cfg_err   = err_q;
  assign err_index = err_idx_q;

endmodule

// File: tb/tb_sccb_init_sequencer.sv
// Directed bench for sccb_init_sequencer with a scripted SCCB slave and write logger.
module tb_sccb_init_sequencer;

  localparam int unsigned P  = 5;
  localparam int unsigned DU = 10;

  logic       clk, rst_n, start;
  logic       sccb_req, sccb_done, sccb_nack;
  logic       busy, cfg_done, cfg_err;
  logic [7:0] sccb_id, sccb_addr, sccb_data, err_index;

  int checks = 0;
  int errors = 0;

  bit   resp_en   = 1'b1;
  int   nack_left = 0;
  int   req_age;
  logic [7:0] wr_addr[$];
  logic [7:0] wr_data[$];
  int         wr_gap[$];
  int         low_run;
  logic       req_prev;

  sccb_init_sequencer #(
    .DEV_ID       (8'h42),
    .PWRUP_CYCLES (P),
    .DELAY_UNIT   (DU),
    .MAX_RETRY    (3)
  ) dut (
    .PCLK      (clk),
    .PRESETN   (rst_n),
    .start     (start),
    .sccb_req  (sccb_req),
    .sccb_id   (sccb_id),
    .sccb_addr (sccb_addr),
    .sccb_data (sccb_data),
    .sccb_done (sccb_done),
    .sccb_nack (sccb_nack),
    .busy      (busy),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err),
    .err_index (err_index)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  // Slave: completes each request on its second cycle high; NACKs 0x11 while nack_left > 0.
  initial begin
    sccb_done = 1'b0;
    sccb_nack = 1'b0;
    req_age   = 0;
    forever begin
      @(negedge clk);
      sccb_done = 1'b0;
      sccb_nack = 1'b0;
      if (!sccb_req || !resp_en) begin
        req_age = 0;
      end else begin
        req_age++;
        if (req_age == 2) begin
          sccb_done = 1'b1;
          if (sccb_addr == 8'h11 && nack_left > 0) begin
            sccb_nack = 1'b1;
            nack_left--;
          end
        end
      end
    end
  end

  // Logs each request rising edge with the number of low samples preceding it.
  initial begin
    req_prev = 1'b0;
    low_run  = 0;
    forever begin
      @(posedge clk);
      #1;
      if (sccb_req && !req_prev) begin
        wr_addr.push_back(sccb_addr);
        wr_data.push_back(sccb_data);
        wr_gap.push_back(low_run);
      end
      if (!sccb_req) low_run++;
      else low_run = 0;
      req_prev = sccb_req;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] get_a(input int i);
    return (i < wr_addr.size()) ? wr_addr[i] : 8'hxx;
  endfunction

  function automatic logic [7:0] get_d(input int i);
    return (i < wr_data.size()) ? wr_data[i] : 8'hxx;
  endfunction

  function automatic int get_g(input int i);
    return (i < wr_gap.size()) ? wr_gap[i] : -1;
  endfunction

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_gap.delete();
  endtask

  task automatic kick();
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_end(input string tag, input int max);
    int n;
    n = 0;
    while (!(cfg_done || cfg_err) && n < max) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(tag, 32'(cfg_done || cfg_err), 32'd1);
  endtask

  initial begin
    int n;
    int cnt11;
    rst_n = 1'b0;
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req",       32'(sccb_req),  32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_cfg_done",  32'(cfg_done),  32'd0);
    chk("rst_cfg_err",   32'(cfg_err),   32'd0);
    chk("rst_addr",      32'(sccb_addr), 32'h00);
    chk("rst_data",      32'(sccb_data), 32'h00);
    chk("rst_err_index", 32'(err_index), 32'h00);
    chk("dev_id",        32'(sccb_id),   32'h42);

    // Start held high through reset must not trigger.
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("noauto_busy", 32'(busy), 32'd0);
    chk("noauto_wr",   32'(wr_addr.size()), 32'd0);

    // First run: latency then full table.
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    n = 0;
    while (!sccb_req && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", 32'(n), 32'(P + 3));
    wait_end("run1_timeout", 1000);
    chk("run1_done",   32'(cfg_done), 32'd1);
    chk("run1_busy",   32'(busy),     32'd0);
    chk("run1_err",    32'(cfg_err),  32'd0);
    chk("run1_nwr",    32'(wr_addr.size()), 32'd3);
    chk("run1_a0",     32'(get_a(0)), 32'h12);
    chk("run1_d0",     32'(get_d(0)), 32'h80);
    chk("run1_a1",     32'(get_a(1)), 32'h11);
    chk("run1_d1",     32'(get_d(1)), 32'h01);
    chk("run1_gap1",   32'(get_g(1)), 32'd2);
    chk("run1_a2",     32'(get_a(2)), 32'h6B);
    chk("run1_d2",     32'(get_d(2)), 32'h0A);
    chk("delay_gap",   32'(get_g(2)), 32'(2 * DU + 3));

    // Restart from DONE replays from index 0.
    clear_log();
    kick();
    chk("replay_busy", 32'(busy),     32'd1);
    chk("replay_nodn", 32'(cfg_done), 32'd0);
    wait_end("replay_timeout", 1000);
    chk("replay_done", 32'(cfg_done), 32'd1);
    chk("replay_nwr",  32'(wr_addr.size()), 32'd3);
    chk("replay_a0",   32'(get_a(0)), 32'h12);

    // Three NACKs then ACK on entry 1.
    clear_log();
    nack_left = 3;
    kick();
    wait_end("retry_timeout", 1000);
    cnt11 = 0;
    foreach (wr_addr[i]) if (wr_addr[i] == 8'h11 && wr_data[i] == 8'h01) cnt11++;
    chk("retry_n11",   32'(cnt11), 32'd4);
    chk("retry_nwr",   32'(wr_addr.size()), 32'd6);
    chk("retry_gap",   32'(get_g(2)), 32'd1);
    chk("retry_a5",    32'(get_a(5)), 32'h6B);
    chk("retry_done",  32'(cfg_done), 32'd1);
    chk("retry_err",   32'(cfg_err),  32'd0);

    // Four NACKs on entry 1 exhausts retries.
    clear_log();
    nack_left = 4;
    kick();
    wait_end("err_timeout", 1000);
    chk("err_flag",    32'(cfg_err),   32'd1);
    chk("err_nodone",  32'(cfg_done),  32'd0);
    chk("err_index",   32'(err_index), 32'd1);
    chk("err_busy",    32'(busy),      32'd0);
    repeat (40) @(posedge clk);
    #1;
    chk("err_nwr",     32'(wr_addr.size()), 32'd5);
    chk("err_hold",    32'(err_index), 32'd1);

    // Reset during WAIT aborts at once; no request until a new start edge.
    clear_log();
    nack_left = 0;
    resp_en   = 1'b0;
    kick();
    n = 0;
    while (!sccb_req && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("abort_reqhi", 32'(sccb_req), 32'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_req",   32'(sccb_req), 32'd0);
    chk("abort_busy",  32'(busy),     32'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    resp_en = 1'b1;
    clear_log();
    repeat (30) @(posedge clk);
    #1;
    chk("abort_nowr",  32'(wr_addr.size()), 32'd0);
    chk("abort_idle",  32'(busy), 32'd0);
    kick();
    wait_end("resume_timeout", 1000);
    chk("resume_done", 32'(cfg_done), 32'd1);
    chk("resume_nwr",  32'(wr_addr.size()), 32'd3);
    chk("resume_a0",   32'(get_a(0)), 32'h12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
